// File: rtl/imem_fetch_ctrl_pkg.sv
// ============================================================================
// rv_pkg : shared constants and state type for the instruction memory
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package rv_pkg;

  localparam logic [31:0] RV_NOP  = 32'h0000_0013;
  localparam int          FLT_MIS = 0;
  localparam int          FLT_RNG = 1;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imem_fetch_ctrl_if.sv
// ============================================================================
// imem_fetch_ctrl_if : program-load and fetch handshake bundle
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

interface imem_fetch_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             prog_we;
  logic [IDX_W-1:0] prog_idx;
  logic [XLEN-1:0]  prog_data;
  logic             prog_done;
  logic             busy;
  logic             req_valid;
  logic             req_ready;
  logic [XLEN-1:0]  req_addr;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [XLEN-1:0]  rsp_instr;
  logic [1:0]       rsp_fault;

  modport master (
    output prog_we, prog_idx, prog_data, prog_done,
    output req_valid, req_addr, rsp_ready,
    input  busy, req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  prog_we, prog_idx, prog_data, prog_done,
    input  req_valid, req_addr, rsp_ready,
    output busy, req_ready, rsp_valid, rsp_instr, rsp_fault
  );

endinterface

`default_nettype wire

// File: rtl/imem_fetch_ctrl_ram.sv
// ============================================================================
// imem_ram_1r1w : DEPTH x XLEN memory, synchronous write, registered read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module imem_ram_1r1w #(
  parameter int DEPTH = 64,
  parameter int XLEN  = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            i_we,
  input  wire logic [AW-1:0]   i_waddr,
  input  wire logic [XLEN-1:0] i_wdata,
  input  wire logic            i_re,
  input  wire logic [AW-1:0]   i_raddr,
  output      logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Array has no reset so it maps onto block RAM; only the read register clears.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
// ============================================================================
// imem_fetch_ctrl : self-clearing instruction memory with valid/ready fetch
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module imem_fetch_ctrl
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  wire logic         clk,
  input  wire logic         reset,
  imem_fetch_ctrl_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_clr_idx;
  logic             r_rsp_valid;
  logic [1:0]       r_rsp_fault;

  logic             w_busy;
  logic             w_req_ready;
  logic             w_we;
  logic [IDX_W-1:0] w_waddr;
  logic [XLEN-1:0]  w_wdata;
  logic [XLEN-1:0]  w_rdata;
  logic             w_mis;
  logic             w_rng;
  logic             w_accept;
  logic             w_re;
  logic [IDX_W-1:0] w_ridx;

  assign w_mis    = |bus.req_addr[1:0];
  assign w_rng    = |(bus.req_addr >> (IDX_W + 2));
  assign w_ridx   = bus.req_addr[IDX_W+1:2];
  assign w_accept = bus.req_valid & w_req_ready;
  assign w_re     = w_accept & ~(w_mis | w_rng);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_CLEAR)) begin
      r_clr_idx <= '0;
    end else begin
      r_clr_idx <= r_clr_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_nxt = ST_LOAD;
      ST_LOAD:  if (bus.prog_done)                  w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // The single write port is shared between the clear sweep and program load.
  always_comb begin
    w_busy      = 1'b0;
    w_req_ready = 1'b0;
    w_we        = 1'b0;
    w_waddr     = '0;
    w_wdata     = '0;
    case (r_state)
      ST_CLEAR: begin
        w_busy  = 1'b1;
        w_we    = 1'b1;
        w_waddr = r_clr_idx;
      end
      ST_LOAD: begin
        w_we    = bus.prog_we;
        w_waddr = bus.prog_idx;
        w_wdata = bus.prog_data;
      end
      ST_RUN: begin
        w_req_ready = ~r_rsp_valid | bus.rsp_ready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= '0;
    end else if (w_accept) begin
      r_rsp_valid          <= 1'b1;
      r_rsp_fault[FLT_MIS] <= w_mis;
      r_rsp_fault[FLT_RNG] <= w_rng;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  imem_ram_1r1w #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (w_ridx),
    .o_rdata (w_rdata)
  );

  // Faulted fetches never read the RAM, so its stale output is masked here.
  assign bus.busy      = w_busy;
  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_fault = r_rsp_fault;
  assign bus.rsp_instr = (|r_rsp_fault) ? XLEN'(RV_NOP) : w_rdata;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
// ============================================================================
// tb_imem_fetch_ctrl : self-checking bench for imem_fetch_ctrl
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_imem_fetch_ctrl;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [31:0] mdl_mem [DEPTH];

  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  imem_fetch_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference: {fault[1:0], instr[31:0]} from the address rules and the loaded image.
  function automatic logic [33:0] mdl_fetch(input logic [31:0] a);
    logic [1:0] f;
    f[0] = (a[1:0] != 2'b00);
    f[1] = (a >= 32'(DEPTH * 4));
    if (f != 2'b00) return {f, NOP};
    return {f, mdl_mem[int'(a >> 2)]};
  endfunction

  task automatic idle_inputs();
    bus.prog_we   = 1'b0;
    bus.prog_idx  = '0;
    bus.prog_data = '0;
    bus.prog_done = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_instr !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_instr: got %h want 0", bus.rsp_instr); end
    n_checks++; if (bus.rsp_fault !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_fault: got %b want 00", bus.rsp_fault); end
  endtask

  task automatic test_clear();
    int   cnt;
    logic rdy_seen;
    cnt = 0;
    rdy_seen = 1'b0;
    reset = 1'b0;
    bus.req_valid = 1'b1;
    #1;
    while (bus.busy === 1'b1 && cnt < 200) begin
      cnt++;
      if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      #1;
    end
    n_checks++; if (cnt != DEPTH) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want %0d", cnt, DEPTH); end
    n_checks++; if (rdy_seen !== 1'b0) begin n_fail++; $display("FAIL clear_no_handshake: got ready/valid seen=%b want 0", rdy_seen); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL load_req_ready: got %b want 0", bus.req_ready); end
    bus.req_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
  endtask

  task automatic test_load();
    for (int i = 0; i < DEPTH; i++) begin
      bus.prog_we   = 1'b1;
      bus.prog_idx  = 6'(i);
      bus.prog_data = $urandom();
      mdl_mem[i]    = bus.prog_data;
      @(negedge clk);
    end
    bus.prog_idx = 6'd1;  bus.prog_data = 32'h0020_80B3; mdl_mem[1]  = bus.prog_data;
    @(negedge clk);
    bus.prog_idx = 6'd63; bus.prog_data = 32'hDEAD_BEEF; mdl_mem[63] = bus.prog_data;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_before_done: got %b want 0", bus.req_ready); end
    bus.prog_idx = 6'd2;  bus.prog_data = 32'h4020_80B3; mdl_mem[2]  = bus.prog_data;
    bus.prog_done = 1'b1;
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL run_req_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h0020_80B3 || bus.rsp_fault !== 2'b00) begin
      n_fail++; $display("FAIL b2b_first: got v=%b i=%h f=%b want v=1 i=002080b3 f=00", bus.rsp_valid, bus.rsp_instr, bus.rsp_fault); end
    bus.req_addr = 32'h8;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b want 1", bus.req_ready); end
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h4020_80B3 || bus.rsp_fault !== 2'b00) begin
      n_fail++; $display("FAIL b2b_second: got v=%b i=%h f=%b want v=1 i=402080b3 f=00", bus.rsp_valid, bus.rsp_instr, bus.rsp_fault); end
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_faults();
    logic [31:0] addrs [4];
    logic [31:0] want_i [4];
    logic [1:0]  want_f [4];
    addrs  = '{32'h6, 32'h100, 32'h102, 32'hFC};
    want_i = '{NOP, NOP, NOP, 32'hDEAD_BEEF};
    want_f = '{2'b01, 2'b10, 2'b11, 2'b00};
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 1'b1; bus.req_addr = addrs[k]; bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== want_i[k] || bus.rsp_fault !== want_f[k]) begin
        n_fail++; $display("FAIL fault_addr_%h: got v=%b i=%h f=%b want v=1 i=%h f=%b",
                           addrs[k], bus.rsp_valid, bus.rsp_instr, bus.rsp_fault, want_i[k], want_f[k]); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    bus.req_valid = 1'b1; bus.req_addr = 32'h4; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_addr = 32'h8;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_instr !== 32'h0020_80B3 || bus.rsp_fault !== 2'b00) begin
        n_fail++; $display("FAIL bp_hold_%0d: got rdy=%b v=%b i=%h f=%b want rdy=0 v=1 i=002080b3 f=00",
                           k, bus.req_ready, bus.rsp_valid, bus.rsp_instr, bus.rsp_fault); end
      @(negedge clk);
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_duplicate: got %b want 0", bus.rsp_valid); end
  endtask

  task automatic test_run_write();
    bus.prog_we = 1'b1; bus.prog_idx = 6'd1; bus.prog_data = 32'hFFFF_FFFF; bus.prog_done = 1'b1;
    @(negedge clk);
    idle_inputs();
    bus.req_valid = 1'b1; bus.req_addr = 32'h4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_checks++; if (bus.rsp_instr !== 32'h0020_80B3) begin n_fail++; $display("FAIL run_write_ignored: got %h want 002080b3", bus.rsp_instr); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic        m_v;
    logic [31:0] m_i;
    logic [1:0]  m_f;
    logic        v, rr, exp_rdy;
    logic [31:0] a;
    int          acc, dut_taken;
    m_v = 1'b0; m_i = '0; m_f = '0; acc = 0; dut_taken = 0;
    for (int c = 0; c < 400; c++) begin
      n_checks++; if (bus.rsp_valid !== m_v) begin n_fail++; $display("FAIL rnd_valid c%0d: got %b want %b", c, bus.rsp_valid, m_v); end
      if (m_v) begin
        n_checks++; if (bus.rsp_instr !== m_i || bus.rsp_fault !== m_f) begin
          n_fail++; $display("FAIL rnd_data c%0d: got i=%h f=%b want i=%h f=%b", c, bus.rsp_instr, bus.rsp_fault, m_i, m_f); end
      end
      v  = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    a = 32'($urandom_range(0, DEPTH - 1) * 4);
        2:       a = 32'($urandom_range(0, DEPTH * 4 - 1));
        default: a = $urandom();
      endcase
      bus.req_valid = v; bus.req_addr = a; bus.rsp_ready = rr;
      #1;
      exp_rdy = !m_v || rr;
      n_checks++; if (bus.req_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.req_ready, exp_rdy); end
      if (bus.rsp_valid === 1'b1 && rr) dut_taken++;
      if (v && exp_rdy) begin
        {m_f, m_i} = mdl_fetch(a);
        m_v = 1'b1;
        acc++;
      end else if (rr) begin
        m_v = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    if (bus.rsp_valid === 1'b1) dut_taken++;
    @(negedge clk);
    n_checks++; if (dut_taken != acc) begin n_fail++; $display("FAIL rnd_transfer_count: got %0d want %0d", dut_taken, acc); end
  endtask

  task automatic test_reset_midop();
    int cnt;
    bus.req_valid = 1'b1; bus.req_addr = 32'h8; bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL midop_pending: got %b want 1", bus.rsp_valid); end
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    n_checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_instr !== 32'h0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL midop_reset: got v=%b i=%h busy=%b want v=0 i=0 busy=1", bus.rsp_valid, bus.rsp_instr, bus.busy); end
    reset = 1'b0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin cnt++; @(negedge clk); end
    n_checks++; if (cnt >= 200) begin n_fail++; $display("FAIL midop_clear_timeout: got %0d cycles want < 200", cnt); end
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
    bus.prog_done = 1'b1;
    @(negedge clk);
    bus.prog_done = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      bus.req_valid = 1'b1; bus.req_addr = 32'(k * 4);
      @(negedge clk);
      bus.req_valid = 1'b0;
      n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_instr !== mdl_mem[k] || bus.rsp_fault !== 2'b00) begin
        n_fail++; $display("FAIL midop_recleared_%0d: got v=%b i=%h f=%b want v=1 i=%h f=00",
                           k, bus.rsp_valid, bus.rsp_instr, bus.rsp_fault, mdl_mem[k]); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_load();
    test_back_to_back();
    test_faults();
    test_backpressure();
    test_run_write();
    test_random();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
